// File: rtl/nanov_load_serialiser_pkg.sv
// Shared nanoV load-path definitions: load funct3 encodings, serialiser state
// encoding, counter width and small decode helpers for load size and alignment.
package nanoV_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } load_state_e;

    function automatic logic is_byte_load(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LBU);
    endfunction

    function automatic logic is_half_load(input logic [2:0] f3);
        return (f3 == F3_LH) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_signed_load(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH);
    endfunction

    // Byte lane the loaded value starts in; word loads (and unknown funct3)
    // always start at lane 0, halfword loads only honour the upper address bit.
    function automatic logic [1:0] byte_offset(input logic [2:0] f3, input logic [1:0] addr);
        logic [1:0] off;
        off = 2'b00;
        if (is_byte_load(f3)) begin
            off = addr;
        end else if (is_half_load(f3)) begin
            off = {addr[1], 1'b0};
        end
        return off;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        if (is_half_load(f3)) begin
            bad = addr[0];
        end else if (!is_byte_load(f3)) begin
            bad = (addr != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/nanov_load_serialiser_if.sv
// Load-word handshake and serial register-file write port of the load serialiser.
interface nanov_load_serialiser_if;
    import nanoV_pkg::*;

    logic                 start;
    logic                 ready;
    logic [XLEN-1:0]      data_in;
    logic [2:0]           funct3;
    logic [1:0]           addr_lo;
    logic                 pause;
    logic                 data_rd;
    logic                 wr_en;
    logic [CNT_W-1:0]     counter;
    logic                 done;
    logic                 misaligned;

    modport master (
        output start, data_in, funct3, addr_lo, pause,
        input  ready, data_rd, wr_en, counter, done, misaligned
    );

    modport slave (
        input  start, data_in, funct3, addr_lo, pause,
        output ready, data_rd, wr_en, counter, done, misaligned
    );

endinterface

// File: rtl/nanov_load_serialiser_extend.sv
// Combinational bit selector: picks bit 'counter' of the aligned load word,
// substituting the sign/zero extension bit above the load size.
module nanoV_load_extend
    import nanoV_pkg::*;
(
    input  logic [XLEN-1:0]  word_i,
    input  logic [2:0]       funct3_i,
    input  logic [CNT_W-1:0] counter_i,
    output logic             data_rd_o
);

    logic            byte_ld;
    logic            half_ld;
    logic            ext_bit;
    logic [XLEN-1:0] ext_vec;

    always_comb begin
        byte_ld = is_byte_load(funct3_i);
        half_ld = is_half_load(funct3_i);
        ext_bit = 1'b0;
        if (is_signed_load(funct3_i)) begin
            ext_bit = byte_ld ? word_i[7] : word_i[15];
        end
    end

    // Build the fully extended word lane by lane, then index it serially.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_ext
            if (gi < 8) begin : g_lane0
                assign ext_vec[gi] = word_i[gi];
            end else if (gi < 16) begin : g_lane1
                assign ext_vec[gi] = byte_ld ? ext_bit : word_i[gi];
            end else begin : g_upper
                assign ext_vec[gi] = (byte_ld || half_ld) ? ext_bit : word_i[gi];
            end
        end
    endgenerate

    assign data_rd_o = ext_vec[counter_i];

endmodule

// File: rtl/nanov_load_serialiser.sv
// nanoV bit-serial load path: aligns/extends a memory word and streams it LSB-first.
// Optional NANOV_LOAD_MISALIGN_TRAP_EN rejects misaligned LH/LHU/LW starts.
module nanov_load_serialiser
    import nanoV_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    nanov_load_serialiser_if.slave bus
);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [XLEN-1:0]  word_q, word_d;
    logic [2:0]       funct3_q, funct3_d;

    logic busy;
    logic advance;
    logic last_bit;
    logic ready;
    logic accept;
    logic reject;
    logic load_go;
    logic ext_bit;

    // Handshake decode; ready depends only on flops and pause.
    always_comb begin
        busy     = (state_q == ST_SHIFT);
        advance  = busy && !bus.pause;
        last_bit = advance && (counter_q == CNT_LAST);
        ready    = !bus.pause && (!busy || (counter_q == CNT_LAST));
        accept   = bus.start && ready;
`ifdef NANOV_LOAD_MISALIGN_TRAP_EN
        reject   = accept && is_misaligned(bus.funct3, bus.addr_lo);
`else
        reject   = 1'b0;
`endif
        load_go  = accept && !reject;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_go) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = load_go ? ST_SHIFT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter wraps 31 -> 0 on the final bit, so IDLE always sees zero.
    always_comb begin
        counter_d = counter_q;
        word_d    = word_q;
        funct3_d  = funct3_q;
        if (load_go) begin
            counter_d = '0;
            word_d    = bus.data_in >> {byte_offset(bus.funct3, bus.addr_lo), 3'b000};
            funct3_d  = bus.funct3;
        end else if (advance) begin
            counter_d = counter_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
            word_q    <= '0;
            funct3_q  <= F3_LW;
        end else begin
            counter_q <= counter_d;
            word_q    <= word_d;
            funct3_q  <= funct3_d;
        end
    end

`ifdef NANOV_LOAD_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= reject;
        end
    end

    assign bus.misaligned = misaligned_q;
`else
    assign bus.misaligned = 1'b0;
`endif

    nanoV_load_extend u_extend (
        .word_i    (word_q),
        .funct3_i  (funct3_q),
        .counter_i (counter_q),
        .data_rd_o (ext_bit)
    );

    always_comb begin
        bus.ready   = ready;
        bus.wr_en   = advance;
        bus.done    = last_bit;
        bus.counter = counter_q;
        bus.data_rd = busy && ext_bit;
    end

endmodule

// File: tb/tb_nanov_load_serialiser.sv
// Directed bench for nanov_load_serialiser: reassembles the serial stream and
// compares against hand-computed load results, latencies and control outputs.
module tb_nanov_load_serialiser;
    import nanoV_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    nanov_load_serialiser_if bus();

    nanov_load_serialiser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    localparam logic [2:0]  EXT_F3   [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LB, 3'b011};
    localparam logic [31:0] EXT_DATA [6] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000,
                                             32'h8001_0000, 32'h7F00_0000, 32'hCAFE_F00D};
    localparam logic [1:0]  EXT_ADDR [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    localparam logic [31:0] EXT_EXP  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                             32'h0000_8001, 32'h0000_007F, 32'hCAFE_F00D};

    // Presents one start for a single cycle; returns #1 after the accepting edge.
    task automatic start_load(input logic [2:0] f3, input logic [31:0] d,
                              input logic [1:0] a, output int scyc);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.funct3  = f3;
        bus.data_in = d;
        bus.addr_lo = a;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.data_in = ~d;
        bus.funct3  = 3'b111;
        scyc        = cyc;
    endtask

    task automatic collect(output logic [31:0] res, output int nwr, output int dcyc,
                           output logic [4:0] dcnt);
        res  = '0;
        nwr  = 0;
        dcyc = -1;
        dcnt = '0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                res[bus.counter] = bus.data_rd;
                nwr++;
            end
            if (bus.done) begin
                dcyc = cyc;
                dcnt = bus.counter;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
        total++; if (bus.counter !== 5'd0) begin bad++; $display("FAIL reset_counter got=%0d want=0", bus.counter); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.data_rd !== 1'b0) begin bad++; $display("FAIL reset_data_rd got=%b want=0", bus.data_rd); end
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b want=0", bus.misaligned); end
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_lw();
        int scyc, nwr, dcyc;
        logic [31:0] res;
        logic [4:0] dcnt;
        start_load(F3_LW, 32'hDEAD_BEEF, 2'd0, scyc);
        collect(res, nwr, dcyc, dcnt);
        total++; if (res !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_result got=%h want=deadbeef", res); end
        total++; if (nwr !== 32) begin bad++; $display("FAIL lw_wr_cycles got=%0d want=32", nwr); end
        total++; if (dcnt !== 5'd31) begin bad++; $display("FAIL lw_done_counter got=%0d want=31", dcnt); end
        total++; if (dcyc - scyc !== 31) begin bad++; $display("FAIL lw_done_latency got=%0d want=31", dcyc - scyc); end
        @(negedge clk);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL lw_idle_wr_en got=%b want=0", bus.wr_en); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL lw_idle_ready got=%b want=1", bus.ready); end
        total++; if (bus.counter !== 5'd0) begin bad++; $display("FAIL lw_idle_counter got=%0d want=0", bus.counter); end
        $display("load LW data=deadbeef result=%h done_latency=%0d", res, dcyc - scyc);
    endtask

    task automatic test_extend();
        int scyc, nwr, dcyc;
        logic [31:0] res;
        logic [4:0] dcnt;
        for (int i = 0; i < 6; i++) begin
            start_load(EXT_F3[i], EXT_DATA[i], EXT_ADDR[i], scyc);
            collect(res, nwr, dcyc, dcnt);
            total++;
            if (res !== EXT_EXP[i]) begin
                bad++;
                $display("FAIL ext_result[%0d] got=%h want=%h", i, res, EXT_EXP[i]);
            end
            total++;
            if (nwr !== 32 || dcyc - scyc !== 31) begin
                bad++;
                $display("FAIL ext_timing[%0d] got wr=%0d lat=%0d want wr=32 lat=31", i, nwr, dcyc - scyc);
            end
            $display("load f3=%0d data=%h addr=%0d result=%h", EXT_F3[i], EXT_DATA[i], EXT_ADDR[i], res);
        end
    endtask

    task automatic test_pause();
        int scyc, nwr, dcyc, npause;
        logic [31:0] res;
        start_load(F3_LW, 32'h1234_5678, 2'd0, scyc);
        res = '0; nwr = 0; dcyc = -1; npause = 0;
        for (int k = 0; k < 80 && dcyc < 0; k++) begin
            if (bus.counter == 5'd7 && npause < 3) begin
                bus.pause = 1'b1;
                npause++;
            end else begin
                bus.pause = 1'b0;
            end
            @(negedge clk);
            if (bus.pause) begin
                total++; if (bus.counter !== 5'd7) begin bad++; $display("FAIL pause_counter got=%0d want=7", bus.counter); end
                total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL pause_wr_en got=%b want=0", bus.wr_en); end
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL pause_done got=%b want=0", bus.done); end
            end
            if (bus.wr_en) begin
                res[bus.counter] = bus.data_rd;
                nwr++;
            end
            if (bus.done) dcyc = cyc;
            @(posedge clk); #1;
        end
        bus.pause = 1'b0;
        total++; if (res !== 32'h1234_5678) begin bad++; $display("FAIL pause_result got=%h want=12345678", res); end
        total++; if (nwr !== 32) begin bad++; $display("FAIL pause_wr_cycles got=%0d want=32", nwr); end
        total++; if (dcyc - scyc !== 34) begin bad++; $display("FAIL pause_done_latency got=%0d want=34", dcyc - scyc); end
        $display("load LW paused x%0d result=%h done_latency=%0d", npause, res, dcyc - scyc);
    endtask

    task automatic test_ignore_start();
        int scyc, dcyc;
        logic [31:0] res;
        start_load(F3_LW, 32'hA5A5_0F0F, 2'd0, scyc);
        res = '0; dcyc = -1;
        for (int k = 0; k < 80 && dcyc < 0; k++) begin
            if (bus.counter == 5'd5) begin
                bus.start = 1'b1; bus.funct3 = F3_LBU; bus.data_in = 32'hFFFF_FFFF; bus.addr_lo = 2'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.wr_en) res[bus.counter] = bus.data_rd;
            if (bus.done) dcyc = cyc;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        total++; if (res !== 32'hA5A5_0F0F) begin bad++; $display("FAIL busy_start_result got=%h want=a5a50f0f", res); end
        total++; if (dcyc - scyc !== 31) begin bad++; $display("FAIL busy_start_latency got=%0d want=31", dcyc - scyc); end
        @(negedge clk);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b want=0", bus.wr_en); end
        $display("load LW with busy start result=%h", res);
    endtask

    task automatic test_back_to_back();
        int scyc, scyc2, nwr, dcyc;
        logic [31:0] res, res2;
        logic [4:0] dcnt;
        logic got_done;
        start_load(F3_LW, 32'h0F0F_1234, 2'd0, scyc);
        res = '0; got_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.counter == 5'd31) begin
                bus.start = 1'b1; bus.funct3 = F3_LBU; bus.data_in = 32'h0000_00AA; bus.addr_lo = 2'd0;
            end
            @(negedge clk);
            if (bus.wr_en) res[bus.counter] = bus.data_rd;
            if (bus.done) begin
                got_done = 1'b1;
                total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", bus.ready); end
                @(posedge clk); #1;
                bus.start = 1'b0; bus.data_in = 32'hFFFF_FFFF;
                break;
            end
            @(posedge clk); #1;
        end
        scyc2 = cyc;
        total++; if (got_done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want=1", got_done); end
        total++; if (res !== 32'h0F0F_1234) begin bad++; $display("FAIL b2b_first_result got=%h want=0f0f1234", res); end
        total++; if (bus.counter !== 5'd0) begin bad++; $display("FAIL b2b_counter got=%0d want=0", bus.counter); end
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en got=%b want=1", bus.wr_en); end
        collect(res2, nwr, dcyc, dcnt);
        total++; if (res2 !== 32'h0000_00AA) begin bad++; $display("FAIL b2b_second_result got=%h want=000000aa", res2); end
        total++; if (dcyc - scyc2 !== 31) begin bad++; $display("FAIL b2b_second_latency got=%0d want=31", dcyc - scyc2); end
        $display("back-to-back first=%h second=%h", res, res2);
    endtask

    task automatic test_reset_mid();
        int scyc, stray;
        logic reached;
        start_load(F3_LW, 32'hFFFF_FFFF, 2'd0, scyc);
        reached = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.counter == 5'd12) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++; if (reached !== 1'b1) begin bad++; $display("FAIL rst_mid_reach got=%b want=1", reached); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en got=%b want=0", bus.wr_en); end
        total++; if (bus.counter !== 5'd0) begin bad++; $display("FAIL rst_mid_counter got=%0d want=0", bus.counter); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", bus.ready); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.wr_en !== 1'b0) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL rst_mid_stray_wr got=%0d want=0", stray); end
        $display("reset mid-transfer at counter 12, stray writes=%0d", stray);
    endtask

    task automatic test_misalign();
        int scyc, nwr, dcyc;
        logic [31:0] res;
        logic [4:0] dcnt;
`ifdef NANOV_LOAD_MISALIGN_TRAP_EN
        start_load(F3_LW, 32'hDEAD_BEEF, 2'd1, scyc);
        total++; if (bus.misaligned !== 1'b1) begin bad++; $display("FAIL trap_lw_pulse got=%b want=1", bus.misaligned); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL trap_lw_wr_en got=%b want=0", bus.wr_en); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL trap_lw_ready got=%b want=1", bus.ready); end
        @(posedge clk); #1;
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL trap_lw_pulse_end got=%b want=0", bus.misaligned); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL trap_lw_wr_en2 got=%b want=0", bus.wr_en); end
        start_load(F3_LHU, 32'h8001_0000, 2'd3, scyc);
        total++; if (bus.misaligned !== 1'b1) begin bad++; $display("FAIL trap_lh_pulse got=%b want=1", bus.misaligned); end
        start_load(F3_LB, 32'h8000_0000, 2'd3, scyc);
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL trap_lb_pulse got=%b want=0", bus.misaligned); end
        collect(res, nwr, dcyc, dcnt);
        total++; if (res !== 32'hFFFF_FF80) begin bad++; $display("FAIL trap_lb_result got=%h want=ffffff80", res); end
        $display("misalign trap checks done, LB addr3 result=%h", res);
`else
        start_load(F3_LW, 32'hDEAD_BEEF, 2'd1, scyc);
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL notrap_lw_pulse got=%b want=0", bus.misaligned); end
        collect(res, nwr, dcyc, dcnt);
        total++; if (res !== 32'hDEAD_BEEF) begin bad++; $display("FAIL notrap_lw_result got=%h want=deadbeef", res); end
        total++; if (nwr !== 32) begin bad++; $display("FAIL notrap_lw_wr got=%0d want=32", nwr); end
        start_load(F3_LHU, 32'h8001_0000, 2'd3, scyc);
        collect(res, nwr, dcyc, dcnt);
        total++; if (res !== 32'h0000_8001) begin bad++; $display("FAIL notrap_lhu_result got=%h want=00008001", res); end
        $display("load LHU addr3 without trap result=%h", res);
`endif
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.pause   = 1'b0;
        bus.data_in = '0;
        bus.funct3  = F3_LW;
        bus.addr_lo = 2'd0;
        test_reset();
        test_lw();
        test_extend();
        test_pause();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
